// File: rtl/led_chase_core.sv
// LED chase reaction game core: a lit LED walks the bar and the player raises the matching switch.
// Optional build macro LED_CHASE_BOUNCE_EN makes the walk reverse at the LSB and return to the MSB.
module led_chase_core #(
    parameter int unsigned N_LEDS     = 10,
    parameter int unsigned LVL_W      = 4,
    parameter int unsigned MAX_LEVEL  = 15,
    parameter int unsigned SCORE_W    = 8,
    parameter int unsigned BASE_TICKS = 20000,
    parameter int unsigned TICK_STEP  = 1000,
    parameter int unsigned MIN_TICKS  = 2000,
    parameter int unsigned LIVES      = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [N_LEDS-1:0]  switch,
    output logic [N_LEDS-1:0]  led,
    output logic [SCORE_W-1:0] score,
    output logic [LVL_W-1:0]   level,
    output logic [2:0]         lives_left,
    output logic               game_over,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_RUN, S_HIT, S_MISS, S_WAIT_REL, S_OVER
    } state_t;

    localparam logic [31:0]        BASE_W     = 32'(BASE_TICKS);
    localparam logic [31:0]        STEP_W     = 32'(TICK_STEP);
    localparam logic [31:0]        MIN_W      = 32'(MIN_TICKS);
    localparam logic [31:0]        SCORE_MAX  = (32'd1 << SCORE_W) - 32'd1;
    localparam logic [LVL_W-1:0]   LVL_MAX    = LVL_W'(MAX_LEVEL);
    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
    localparam logic [N_LEDS-1:0]  LED_MSB    = {1'b1, {(N_LEDS-1){1'b0}}};

    state_t              r_state, w_state_next;
    logic                r_start_s1, r_start_s2, r_start_prev;
    logic [N_LEDS-1:0]   r_sw_s1, r_sw_q, r_sw_prev;
    logic [N_LEDS-1:0]   r_led;
    logic [31:0]         r_cnt;
    logic [SCORE_W-1:0]  r_score;
    logic [LVL_W-1:0]    r_level;
    logic [2:0]          r_lives;

    logic                w_start_evt, w_press, w_at_end, w_step;
    logic [N_LEDS-1:0]   w_led_shift;
    logic [31:0]         w_dec, w_raw, w_period, w_sum;
    logic [SCORE_W-1:0]  w_score_inc;

    // Start key idles high, so its synchroniser resets high to avoid a phantom press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_start_s1   <= 1'b1;
            r_start_s2   <= 1'b1;
            r_start_prev <= 1'b1;
            r_sw_s1      <= '0;
            r_sw_q       <= '0;
            r_sw_prev    <= '0;
        end else begin
            r_start_s1   <= start;
            r_start_s2   <= r_start_s1;
            r_start_prev <= r_start_s2;
            r_sw_s1      <= switch;
            r_sw_q       <= r_sw_s1;
            r_sw_prev    <= r_sw_q;
        end
    end

    assign w_start_evt = r_start_prev && !r_start_s2;
    assign w_press     = (r_sw_q != '0) && (r_sw_prev == '0);

    // Saturating subtraction keeps high levels from wrapping to a huge period.
    assign w_dec    = 32'(r_level) * STEP_W;
    assign w_raw    = (w_dec >= BASE_W) ? 32'd0 : (BASE_W - w_dec);
    assign w_period = (w_raw < MIN_W) ? MIN_W : w_raw;

    assign w_sum       = 32'(r_score) + 32'(r_level) + 32'd1;
    assign w_score_inc = (w_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : w_sum[SCORE_W-1:0];

    assign w_step = (r_state == S_RUN) && !w_press && (r_cnt == '0) && !w_at_end;

`ifdef LED_CHASE_BOUNCE_EN
    logic r_dir;  // 1 = travelling back toward the MSB

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dir <= 1'b0;
        end else if (r_state == S_ARM) begin
            r_dir <= 1'b0;
        end else if (w_step && !r_dir && r_led[0]) begin
            r_dir <= 1'b1;
        end
    end

    assign w_at_end    = r_dir && r_led[N_LEDS-1];
    assign w_led_shift = (r_dir || r_led[0]) ? (r_led << 1) : (r_led >> 1);
`else
    assign w_at_end    = r_led[0];
    assign w_led_shift = r_led >> 1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: default assigned first so no path through the case can infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:     if (w_start_evt) w_state_next = S_ARM;
            S_ARM:      w_state_next = S_RUN;
            S_RUN: begin
                if (w_press) begin
                    w_state_next = (r_sw_q == r_led) ? S_HIT : S_MISS;
                end else if ((r_cnt == '0) && w_at_end) begin
                    w_state_next = S_MISS;
                end
            end
            S_HIT:      w_state_next = S_WAIT_REL;
            S_MISS:     w_state_next = (r_lives <= 3'd1) ? S_OVER : S_WAIT_REL;
            S_WAIT_REL: if (r_sw_q == '0) w_state_next = S_ARM;
            S_OVER:     if (w_start_evt) w_state_next = S_ARM;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_led   <= '0;
            r_cnt   <= '0;
            r_score <= '0;
            r_level <= '0;
            r_lives <= LIVES_INIT;
        end else begin
            unique case (r_state)
                S_IDLE, S_OVER: begin
                    if (w_start_evt) begin
                        r_score <= '0;
                        r_level <= '0;
                        r_lives <= LIVES_INIT;
                    end
                end
                S_ARM: begin
                    r_led <= LED_MSB;
                    r_cnt <= w_period - 32'd1;
                end
                S_RUN: begin
                    if (w_step) begin
                        r_led <= w_led_shift;
                        r_cnt <= w_period - 32'd1;
                    end else if (!w_press && (r_cnt != '0)) begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                S_HIT: begin
                    r_score <= w_score_inc;
                    if (r_level < LVL_MAX) r_level <= r_level + LVL_W'(1);
                end
                S_MISS: begin
                    r_lives <= r_lives - 3'd1;
                    if (r_lives <= 3'd1) begin
                        r_led <= '1;
                    end else if (r_level != '0) begin
                        r_level <= r_level - LVL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign led        = r_led;
    assign score      = r_score;
    assign level      = r_level;
    assign lives_left = r_lives;
    assign game_over  = (r_state == S_OVER);
    assign busy       = (r_state != S_IDLE) && (r_state != S_OVER);

endmodule

// File: tb/tb_led_chase_core.sv
// Directed bench for led_chase_core: scoreboard of expected score/level/lives around each press.
module tb_led_chase_core;

    localparam int N = 10;
`ifdef LED_CHASE_BOUNCE_EN
    localparam int NPOS = 2 * N - 1;
`else
    localparam int NPOS = N;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] switch;
    logic [N-1:0] led;
    logic [7:0]   score;
    logic [3:0]   level;
    logic [2:0]   lives_left;
    logic         game_over;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int m_score, m_level, m_lives;
    logic [31:0] sb_q[$];

    led_chase_core #(
        .N_LEDS(N), .LVL_W(4), .MAX_LEVEL(15), .SCORE_W(8),
        .BASE_TICKS(20), .TICK_STEP(2), .MIN_TICKS(4), .LIVES(3)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .switch(switch),
        .led(led), .score(score), .level(level), .lives_left(lives_left),
        .game_over(game_over), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] v);
        sb_q.push_back(v);
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: got %0h expected <scoreboard empty>", tag, obs);
        end else begin
            e = sb_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    function automatic logic [N-1:0] pos_led(input int p);
        logic [N-1:0] one;
        one = 1;
        if (p < N) return one << (N - 1 - p);
        return one << (p - N + 1);
    endfunction

    task automatic wait_led(input logic [N-1:0] tgt, input string tag);
        int k;
        k = 0;
        while (led !== tgt && k < 2000) begin
            tick(1);
            k++;
        end
        check(tag, 32'(led), 32'(tgt));
    endtask

    task automatic push_model();
        sb_push(32'(m_score));
        sb_push(32'(m_level));
        sb_push(32'(m_lives));
    endtask

    task automatic pop_model(input string pfx);
        sb_check({pfx, "_score"}, 32'(score));
        sb_check({pfx, "_level"}, 32'(level));
        sb_check({pfx, "_lives"}, 32'(lives_left));
    endtask

    task automatic start_game();
        start = 1'b0;
        tick(4);
        start = 1'b1;
        m_score = 0;
        m_level = 0;
        m_lives = 3;
        push_model();
        check("start_led", 32'(led), 32'h200);
        check("start_busy", 32'(busy), 32'd1);
        pop_model("start");
    endtask

    task automatic hit_at(input logic [N-1:0] tgt);
        wait_led(tgt, "hit_wait");
        switch  = tgt;
        m_score = (m_score + m_level + 1 > 255) ? 255 : m_score + m_level + 1;
        m_level = (m_level < 15) ? m_level + 1 : 15;
        push_model();
        tick(4);
        pop_model("hit");
        switch = '0;
        tick(4);
        check("hit_rearm_led", 32'(led), 32'h200);
    endtask

    task automatic miss_at(input logic [N-1:0] tgt, input logic [N-1:0] wrong);
        wait_led(tgt, "miss_wait");
        switch  = wrong;
        m_lives = m_lives - 1;
        if (m_lives != 0 && m_level > 0) m_level = m_level - 1;
        push_model();
        tick(4);
        pop_model("miss");
        switch = '0;
        tick(4);
        if (m_lives == 0) begin
            check("over_flag", 32'(game_over), 32'd1);
            check("over_led", 32'(led), 32'h3FF);
            check("over_busy", 32'(busy), 32'd0);
        end else begin
            check("miss_rearm_led", 32'(led), 32'h200);
        end
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b1;
        switch = '0;
        tick(3);
        check("rst_led", 32'(led), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_lives", 32'(lives_left), 32'd3);
        check("rst_over", 32'(game_over), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick(2);

        // Unpressed walk to the end position, with a start pulse mid-walk that must be ignored.
        start_game();
        tick(19);
        check("walk_hold", 32'(led), 32'(pos_led(0)));
        tick(1);
        check("walk_p1", 32'(led), 32'(pos_led(1)));
        for (int p = 2; p < NPOS; p++) begin
            if (p == 3) start = 1'b0;
            if (p == 5) start = 1'b1;
            tick(20);
            check("walk_pos", 32'(led), 32'(pos_led(p)));
        end
        tick(21);
        m_lives = 2;
        push_model();
        pop_model("timeout");
        check("timeout_led_frozen", 32'(led), 32'(pos_led(NPOS - 1)));
        tick(2);
        check("timeout_rearm", 32'(led), 32'h200);

        // Hit at 0x040, hold the switch, then confirm the level-1 period of 18.
        tick(60);
        check("reach_040", 32'(led), 32'h040);
        switch  = 10'h040;
        m_score = 1;
        m_level = 1;
        push_model();
        tick(4);
        pop_model("first_hit");
        tick(30);
        check("held_led", 32'(led), 32'h040);
        check("held_score", 32'(score), 32'd1);
        switch = '0;
        tick(4);
        check("release_rearm", 32'(led), 32'h200);
        tick(17);
        check("p18_hold", 32'(led), 32'h200);
        tick(1);
        check("p18_shift", 32'(led), 32'h100);

        // Climb to level 3 / score 6, wrong press, then lose the last life.
        hit_at(10'h040);
        hit_at(10'h040);
        miss_at(10'h080, 10'h002);
        miss_at(10'h200, 10'h001);
        tick(10);
        check("over_score_frozen", 32'(score), 32'd6);
        check("over_level_frozen", 32'(level), 32'd2);
        check("over_led_frozen", 32'(led), 32'h3FF);

        // Fresh game, three straight misses at level 0.
        start_game();
        miss_at(10'h200, 10'h001);
        miss_at(10'h200, 10'h001);
        miss_at(10'h200, 10'h001);

        // Saturation of level and score; minimum period at top level.
        start_game();
        for (int i = 0; i < 25; i++) hit_at(10'h200);
        check("sat_level", 32'(level), 32'd15);
        check("sat_score", 32'(score), 32'd255);
        tick(3);
        check("pmin_hold", 32'(led), 32'h200);
        tick(1);
        check("pmin_shift1", 32'(led), 32'h100);
        tick(4);
        check("pmin_shift2", 32'(led), 32'h080);

        // Reach score 9, then reset mid-run.
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        start_game();
        hit_at(10'h200);
        hit_at(10'h200);
        hit_at(10'h200);
        miss_at(10'h200, 10'h001);
        hit_at(10'h200);
        tick(5);
        check("pre_rst_score", 32'(score), 32'd9);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_led", 32'(led), 32'd0);
        check("mid_rst_score", 32'(score), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_lives", 32'(lives_left), 32'd3);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_over", 32'(game_over), 32'd0);
        start = 1'b0;
        tick(3);
        start = 1'b1;
        tick(2);
        check("in_rst_led", 32'(led), 32'd0);
        reset = 1'b1;
        tick(8);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_led", 32'(led), 32'd0);
        start_game();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_chase_core.md
Name: led_chase_core

Overview:
- Parametrised successor of the single-board LED reaction game.
- A lit LED walks across an N-wide bar. The player must raise the one switch under the lit LED before the walk finishes.
- Adds configurable width, level speed curve, lives, saturating score, press-edge detection and a game-over state.
- Sits between the board switches/keys and the seven-segment decoders; drives the LED bar directly.

Parameters:
- N_LEDS, 10, LED/switch bar width (>=2).
- LVL_W, 4, level counter width.
- MAX_LEVEL, 15, level saturation value (< 2^LVL_W).
- SCORE_W, 8, score width.
- BASE_TICKS, 20000, step period at level 0, in clocks.
- TICK_STEP, 1000, period decrement per level.
- MIN_TICKS, 2000, floor of step period.
- LIVES, 3, misses allowed before game over (1..7).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  active-low start key
- switch  in  N_LEDS  player switches
- led  out  N_LEDS  LED bar
- score  out  SCORE_W  binary score
- level  out  LVL_W  current level
- lives_left  out  3  remaining lives
- game_over  out  1  high in OVER
- busy  out  1  high in any state except IDLE/OVER

Behaviour:
- Reset (reset=0, async): state=IDLE, led=0, score=0, level=0, lives_left=LIVES, game_over=0, busy=0, step counter=0, switch history=0. Reset asserted mid-game aborts immediately; no partial update survives.
- Inputs: start and switch each pass a 2-flop synchroniser.
  - start_evt = synchronised start falling edge.
  - press = sw_q!=0 while sw_q_prev==0 (all-zero to nonzero transition).
- Period = max(MIN_TICKS, BASE_TICKS - level*TICK_STEP), computed in 32-bit unsigned with no underflow wrap.
- States:
  - IDLE: led=0. start_evt -> ARM, clearing score, level and lives (to LIVES).
  - ARM (1 cycle): led = MSB one-hot; counter = period-1 -> RUN.
  - RUN, priority order:
    - press: sw_q==led -> HIT, else -> MISS.
    - counter!=0: decrement.
    - counter==0 and led not at end position: shift toward LSB; reload period-1.
    - counter==0 and led at end position -> MISS.
    - Press wins over a simultaneous timeout.
  - HIT (1 cycle):
    - score += level+1, saturating at 2^SCORE_W-1.
    - level += 1, saturating at MAX_LEVEL.
    - -> WAIT_REL.
  - MISS (1 cycle): lives_left -= 1.
    - If it becomes 0 -> OVER.
    - Otherwise level -= 1 (floor 0) -> WAIT_REL.
  - WAIT_REL: led frozen. sw_q==0 -> ARM. A held switch never retriggers.
  - OVER: game_over=1; led = all ones; score/level frozen. start_evt -> ARM with fresh game (score=0, level=0, lives=LIVES).
- Latency:
  - Press detected at edge E; state=HIT/MISS after edge E+1.
  - score/level/lives visible after edge E+2.
- start_evt while busy is ignored.
- Exactly one led bit is set in ARM/RUN/WAIT_REL.

Optional Feature:
- Macro: LED_CHASE_BOUNCE_EN.
- Defined:
  - The walk reverses at the LSB and travels back toward the MSB.
  - The end position is the MSB reached on the return leg, giving 2*N_LEDS-1 positions per round.
  - A direction register is reset to "down" in ARM.
  - A correct press on either leg is a HIT; scoring is unchanged.
- Undefined:
  - The walk is MSB to LSB only; the end position is the LSB.
  - No direction register is synthesised.

Test Plan (N_LEDS=10, BASE_TICKS=20, TICK_STEP=2, MIN_TICKS=4, LIVES=3):
- Reset then start pulse -> ARM; led=10'h200; led shifts right every 20 clocks; timeout at led=10'h001 -> lives_left=2, level stays 0, state WAIT_REL.
- With led=10'h040, set switch=10'h040 -> two edges later score=1, level=1. Next round period is 18 clocks. Holding the switch keeps led frozen until switch=0.
- At level 3, score=6, press wrong switch 10'h002 while led=10'h080 -> lives_left decrements, level=2, score=6.
- Three consecutive misses -> game_over=1, led=10'h3FF. Start pulse -> score=0, level=0, lives_left=3, led=10'h200.
- Play to level 15 with score near 250 -> level holds 15, period=4, score saturates at 255.
- Assert reset mid-RUN with score=9 -> all outputs at reset values within the same cycle; start pulse ignored until reset released and next falling edge. With LED_CHASE_BOUNCE_EN defined: led sequence 200…001…200, and miss occurs only after 19 steps.
